// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared FSM encodings, requester sizing and round-robin winner search
package mux_arb_pkg;
  localparam logic IDLE = 1'b0;
  localparam logic GRANT = 1'b1;
  localparam int NREQ = 4;
  localparam int IDX_W = 2;
  // Scanning from farthest to nearest lets the nearest requester after ptr win; ptr itself is last.
  function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0] ptr, input logic [NREQ-1:0] req);
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] idx;
    r = ptr;
    for (int k = NREQ - 1; k >= 1; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) r = idx;
    end
    return r;
  endfunction
endpackage

// File: rtl/mux_4x1_nbits.sv
// mux_4x1_nbits: 4-to-1 multiplexer of n-bit words
module mux_4x1_nbits #(
  parameter int n = 4
) (
  input  logic [n-1:0] w0,
  input  logic [n-1:0] w1,
  input  logic [n-1:0] w2,
  input  logic [n-1:0] w3,
  input  logic [1:0]   s,
  output logic [n-1:0] f
);
  always_comb f = s[1] ? (s[0] ? w3 : w2) : (s[0] ? w1 : w0);
endmodule

// File: rtl/mux_rr_arbiter_4x1.sv
// mux_rr_arbiter_4x1: round-robin share of one registered n-bit channel among four requesters.
// Burst hold is compiled in with MUX_RR_ARBITER_BURST_EN.
module mux_rr_arbiter_4x1
  import mux_arb_pkg::*;
#(
  parameter int n = 4,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] w0,
  input  logic [n-1:0] w1,
  input  logic [n-1:0] w2,
  input  logic [n-1:0] w3,
  input  logic [3:0]   req,
  output logic [3:0]   ack,
  output logic [n-1:0] f,
  output logic         f_valid,
  input  logic         f_ready,
  output logic [1:0]   s,
  output logic         busy
);
  logic load;
  logic state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [n-1:0] mux_f;
  assign load = !f_valid | f_ready;
`ifdef MUX_RR_ARBITER_BURST_EN
  logic [4:0] cnt;
  logic hold;
  assign hold = state == GRANT && req[ptr] && cnt < 5'(BURST);
  assign win = hold ? ptr : next_rr(ptr, req);
`else
  assign win = next_rr(ptr, req);
`endif
  // Gated by rst so a request seen during reset is never acknowledged.
  assign ack = (!rst && load && |req) ? 4'b0001 << win : 4'b0000;
  assign busy = state == GRANT;
  mux_4x1_nbits #(.n(n)) u_mux (
    .w0(w0),
    .w1(w1),
    .w2(w2),
    .w3(w3),
    .s(win),
    .f(mux_f)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      f <= '0;
      f_valid <= 1'b0;
      s <= 2'd0;
      ptr <= 2'd3;
      state <= IDLE;
`ifdef MUX_RR_ARBITER_BURST_EN
      cnt <= 5'd0;
`endif
    end else if (load) begin
      if (|req) begin
        f <= mux_f;
        f_valid <= 1'b1;
        s <= win;
        ptr <= win;
        state <= GRANT;
`ifdef MUX_RR_ARBITER_BURST_EN
        cnt <= hold ? cnt + 5'd1 : 5'd1;
`endif
      end else begin
        f_valid <= 1'b0;
        state <= IDLE;
`ifdef MUX_RR_ARBITER_BURST_EN
        cnt <= 5'd0;
`endif
      end
    end
  end
endmodule
